ins_fetcher: RTL and testbench
==============================

Name: ins_fetcher

Overview:
Front-end fetch stage that sits directly upstream of the dispatcher. It requests 32-bit instructions from the memory controller and buffers them in a small in-order instruction queue. Each cycle it hands at most one instruction to the dispatcher, gated by downstream back-pressure. It predicts the next PC using a 2-bit BHT plus static target decode, and redirects on ROB rollback.

Parameters:
IQ_DEPTH, 4, instruction queue entries (power of two)
BHT_BITS, 6, log2 of BHT entry count; index = pc[BHT_BITS+1:2]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = freeze all state
rollback_signal  in  1  ROB misprediction flush
rollback_pc  in  32  correct PC after flush
upd_valid  in  1  ROB commits a conditional branch
upd_pc  in  32  PC of committed branch
upd_taken  in  1  actual outcome
stall  in  1  OR of rob_full, rs_full and lsb_full (each asserted with one-slot margin)
mem_req  out  1  fetch request, held until ack
mem_addr  out  32  fetch address
mem_ack  in  1  one-cycle pulse, mem_instr valid
mem_instr  in  32  fetched word
valid_2disp  out  1  one-cycle pulse per delivered instruction
pc_2disp  out  32  instruction PC
instr_2disp  out  32  instruction word
pred_jump_2disp  out  1  predicted-taken flag

Behaviour:
- Reset (rst=1): pc=0, mem_req=0, mem_addr=0, valid_2disp=0, pc_2disp=0, instr_2disp=0, pred_jump_2disp=0. Queue empty (head=tail=count=0). All BHT counters=2'b01. FSM=IDLE. Reset takes priority over rollback and rdy.
- rdy=0: no register changes. mem_req and mem_addr hold their values. The memory controller never pulses mem_ack while rdy=0.
- FSM IDLE: if count+0 < IQ_DEPTH, assert mem_req, mem_addr=pc, go to BUSY.
- FSM BUSY: on mem_ack, drop mem_req, push {pc, mem_instr, pred} to the tail, set pc=next_pc, go to IDLE. A new request is therefore issued one cycle after ack at the earliest.
- FSM FLUSH: keep mem_req and the stale address until mem_ack. Discard the returned word, drop mem_req, go to IDLE. pc is already the rollback target.
- next_pc / pred are combinational on mem_instr and pc:
  - JAL (opcode 1101111): pred=1, target pc+J-imm (sign-extended).
  - BRANCH (1100011): pred=BHT[idx][1]; if 1, target pc+B-imm, else pc+4.
  - JALR and all others: pred=0, next_pc=pc+4.
- Dispatch: if count>0 and !stall, pop the head and register it onto *_2disp with valid_2disp=1. Otherwise valid_2disp=0 and the data outputs hold. Latency is at least one cycle from push to valid_2disp. Push and pop in the same cycle leave count unchanged.
- Full queue: no new request is issued. A request already in flight always has a reserved slot, because a request is issued only when count<IQ_DEPTH and the pop/push pair is balanced.
- Empty queue with stall=0: valid_2disp=0.
- rollback_signal (rdy=1) overrides everything else:
  - Queue cleared, valid_2disp=0, pc=rollback_pc.
  - If FSM=BUSY and no mem_ack this cycle, go to FLUSH.
  - If mem_ack arrives this cycle, discard it, drop mem_req, go to IDLE.
  - If FSM=IDLE, stay IDLE.
  - A rollback while in FLUSH updates pc only.
- BHT update: on upd_valid, the counter at upd_pc[BHT_BITS+1:2] saturating-increments if upd_taken, else decrements (range 00..11). The update applies even during rollback. If an update and a lookup hit the same index in one cycle, the lookup sees the old value.
- Pointer arithmetic is mod IQ_DEPTH. count is $clog2(IQ_DEPTH)+1 bits wide.

Decomposition:
- Shared header const.v: opcode macros (JAL, JALR, BRANCH), DATA_IDX_RANGE, TRUE/FALSE, and the fetch-FSM state encodings.
- One sub-module, branch_predictor: BHT storage, lookup port and update port, parameterised by BHT_BITS.
- Immediate extraction (J/B) and the queue stay inside ins_fetcher.

Test Plan:
- Reset, then memory returns ADDI words at 0x0, 0x4, 0x8 with 1-cycle ack latency, stall=0 -> valid_2disp pulses with pc 0x0, 0x4, 0x8 in order; pred_jump_2disp=0.
- JAL at 0x10 with imm=+0x20 -> next mem_addr=0x30; dispatched entry has pred_jump_2disp=1.
- BEQ at 0x40 imm=-8: first fetch predicts not-taken (next 0x44). Two upd_valid/upd_taken=1 at 0x40, refetch 0x40 -> mem_addr next=0x38, pred=1.
- stall=1 for 10 cycles -> exactly IQ_DEPTH=4 words fetched, mem_req stays 0 afterwards, no valid_2disp. Release -> 4 consecutive pulses, then fetching resumes.
- rollback_pc=0x100 asserted while BUSY on addr 0x8; ack arrives 3 cycles later -> word discarded, queue empty, next mem_addr=0x100, first delivered pc=0x100.
- rollback coincident with mem_ack, plus rdy=0 for 5 cycles mid-BUSY -> ack word dropped, no outputs change while rdy=0, fetch resumes from rollback_pc.

Source files
------------

// File: rtl/ins_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, fetch FSM
// states, queue entry layout and branch-history counter constants.
package ins_fetcher_pkg;

  localparam int          DATA_W     = 32;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  // Two-bit saturating counter bounds and the weakly-not-taken reset value
  localparam logic [1:0]  CTR_MIN  = 2'b00;
  localparam logic [1:0]  CTR_MAX  = 2'b11;
  localparam logic [1:0]  CTR_INIT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              pred;
  } iq_entry_t;

endpackage

// File: rtl/ins_fetcher_bp.sv
// Branch history table: one 2-bit saturating counter per index, with an
// asynchronous lookup port and a registered update port. A lookup that
// collides with an update in the same cycle sees the pre-update counter.
module branch_predictor
  import ins_fetcher_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [BHT_BITS-1:0] lookup_idx,
  output logic                lookup_taken,
  input  logic                upd_valid,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int BHT_SIZE = 1 << BHT_BITS;

  logic [1:0] bht_reg [BHT_SIZE];
  logic [1:0] upd_cur;
  logic [1:0] upd_next;

  assign lookup_taken = bht_reg[lookup_idx][1];
  assign upd_cur      = bht_reg[upd_idx];

  // Saturating step of the counter being trained
  always_comb begin
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != CTR_MIN) upd_next = upd_cur - 2'b01;
    end
  end

  // Counter storage: all entries start weakly not-taken
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) bht_reg[i] <= CTR_INIT;
    end else if (rdy && upd_valid) begin
      bht_reg[upd_idx] <= upd_next;
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Fetch stage: one outstanding memory request at a time, a small in-order
// instruction queue, next-PC prediction (JAL always, branches via BHT) and
// rollback redirect. At most one instruction per cycle goes to dispatch.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_signal,
  input  logic [31:0] rollback_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_instr,
  output logic        valid_2disp,
  output logic [31:0] pc_2disp,
  output logic [31:0] instr_2disp,
  output logic        pred_jump_2disp
);

  localparam int               PTR_W   = $clog2(IQ_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] IQ_FULL = CNT_W'(IQ_DEPTH);

  fetch_state_t      state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic              mem_req_reg, mem_req_next;
  logic [31:0]       mem_addr_reg, mem_addr_next;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              valid_reg;
  logic [31:0]       disp_pc_reg, disp_instr_reg;
  logic              disp_pred_reg;

  iq_entry_t         iq_mem [IQ_DEPTH];
  iq_entry_t         head_entry;

  logic              bht_taken;
  logic              pred_taken;
  logic [31:0]       fetch_next_pc;
  logic [31:0]       j_imm, b_imm;
  logic              issue_req, push, pop, ack_done;
  logic              unused_upd_bits;

  // Only the index bits of the committed branch PC train the table
  assign unused_upd_bits = ^{upd_pc[31:BHT_BITS+2], upd_pc[1:0]};

  branch_predictor #(.BHT_BITS(BHT_BITS)) u_bp (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .lookup_idx   (pc_reg[BHT_BITS+1:2]),
    .lookup_taken (bht_taken),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_pc[BHT_BITS+1:2]),
    .upd_taken    (upd_taken)
  );

  // J-type and B-type immediates, sign-extended
  assign j_imm = {{11{mem_instr[31]}}, mem_instr[31], mem_instr[19:12],
                  mem_instr[20], mem_instr[30:21], 1'b0};
  assign b_imm = {{19{mem_instr[31]}}, mem_instr[31], mem_instr[7],
                  mem_instr[30:25], mem_instr[11:8], 1'b0};

  // Static target decode of the returning word plus BHT direction
  always_comb begin
    pred_taken    = 1'b0;
    fetch_next_pc = pc_reg + 32'd4;
    case (mem_instr[6:0])
      OPC_JAL: begin
        pred_taken    = 1'b1;
        fetch_next_pc = pc_reg + j_imm;
      end
      OPC_BRANCH: begin
        if (bht_taken) begin
          pred_taken    = 1'b1;
          fetch_next_pc = pc_reg + b_imm;
        end
      end
      // Indirect target is unknown here, so fall through sequentially
      OPC_JALR: pred_taken = 1'b0;
      default:  pred_taken = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)      state_reg <= ST_IDLE;
    else if (rdy) state_reg <= state_next;
  end

  // FSM next state: a rollback during an open request must still wait for its ack
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!rollback_signal && (count_reg < IQ_FULL)) state_next = ST_BUSY;
      ST_BUSY: begin
        if (mem_ack)              state_next = ST_IDLE;
        else if (rollback_signal) state_next = ST_FLUSH;
      end
      ST_FLUSH: if (mem_ack) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: request handshake, queue push/pop and PC redirect
  always_comb begin
    issue_req     = (state_reg == ST_IDLE) && !rollback_signal && (count_reg < IQ_FULL);
    ack_done      = (state_reg != ST_IDLE) && mem_ack;
    push          = (state_reg == ST_BUSY) && mem_ack && !rollback_signal;
    pop           = (count_reg != '0) && !stall && !rollback_signal;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    if (issue_req) begin
      mem_req_next  = 1'b1;
      mem_addr_next = pc_reg;
    end
    if (ack_done) mem_req_next = 1'b0;
    pc_next = pc_reg;
    if (rollback_signal) pc_next = rollback_pc;
    else if (push)       pc_next = fetch_next_pc;
  end

  // Queue storage; the tail slot is always free when a word is pushed
  always_ff @(posedge clk) begin
    if (!rst && rdy && push) begin
      iq_mem[tail_reg] <= '{pc: pc_reg, instr: mem_instr, pred: pred_taken};
    end
  end

  assign head_entry = iq_mem[head_reg];

  // Datapath registers: PC, memory port, queue pointers and dispatch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      valid_reg      <= 1'b0;
      disp_pc_reg    <= '0;
      disp_instr_reg <= '0;
      disp_pred_reg  <= 1'b0;
    end else if (rdy) begin
      pc_reg       <= pc_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      if (rollback_signal) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= pop;
        if (push) tail_reg <= tail_reg + PTR_W'(1);
        if (pop) begin
          head_reg       <= head_reg + PTR_W'(1);
          disp_pc_reg    <= head_entry.pc;
          disp_instr_reg <= head_entry.instr;
          disp_pred_reg  <= head_entry.pred;
        end
        if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
        else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign mem_req         = mem_req_reg;
  assign mem_addr        = mem_addr_reg;
  assign valid_2disp     = valid_reg;
  assign pc_2disp        = disp_pc_reg;
  assign instr_2disp     = disp_instr_reg;
  assign pred_jump_2disp = disp_pred_reg;

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: directed scenarios, a memory responder, and a
// transaction-level model (expected fetch PC, FIFO of fetched words, BHT
// counters) checked on every cycle, plus literal expectations.
module tb_ins_fetcher;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, rollback_signal, upd_valid, upd_taken, stall;
  logic [31:0] rollback_pc, upd_pc;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_instr;
  logic        valid_2disp, pred_jump_2disp;
  logic [31:0] pc_2disp, instr_2disp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_delay = 1;

  // model state
  logic [31:0] m_pc;
  ent_t        m_q[$];
  int          m_bht[64];
  bit          m_discard;
  int          m_acc;
  logic [31:0] req_log[$];
  ent_t        disp_log[$];
  int          disp_cyc[$];
  int          rb_req_idx, rb_disp_idx;

  ins_fetcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rollback_signal(rollback_signal), .rollback_pc(rollback_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_instr(mem_instr),
    .valid_2disp(valid_2disp), .pc_2disp(pc_2disp), .instr_2disp(instr_2disp),
    .pred_jump_2disp(pred_jump_2disp)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program image: JAL +0x20 at 0x10, BEQ -8 at 0x40, distinct ADDIs elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0200006F;
      32'h40:  return 32'hFE000CE3;
      default: return {a[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  // Architectural next-PC rule
  function automatic void model_next(input logic [31:0] pc, input logic [31:0] w, input int ctr,
                                     output logic [31:0] npc, output bit pr);
    logic [31:0] imm;
    pr  = 1'b0;
    npc = pc + 32'd4;
    if (w[6:0] == 7'b1101111) begin
      imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      pr  = 1'b1;
      npc = pc + imm;
    end else if (w[6:0] == 7'b1100011 && ctr >= 2) begin
      imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      pr  = 1'b1;
      npc = pc + imm;
    end
  endfunction

  // Memory controller: acks ack_delay cycles after seeing a request, never while rdy=0
  initial begin : mem_proc
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_instr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (rst || !rdy || !mem_req) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_instr = mem_word(mem_addr);
          wait_cnt  = 0;
        end
      end
    end
  end

  // Model + compare: observe the last edge, then apply the inputs of the next edge
  initial begin : model_proc
    bit          last_frozen, last_active, last_stall, prev_req;
    logic [98:0] snap, now;
    ent_t        e, o;
    logic [31:0] npc;
    bit          pr;
    int          idx;
    last_frozen = 0; last_active = 0; last_stall = 0; prev_req = 0; snap = '0;
    m_pc = 0; m_discard = 0; m_acc = 0; rb_req_idx = 0; rb_disp_idx = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    forever begin
      @(negedge clk);
      now = {mem_req, mem_addr, valid_2disp, pc_2disp, instr_2disp, pred_jump_2disp};
      if (last_frozen) begin
        checks++;
        if (now !== snap) begin
          failures++;
          $display("FAIL freeze_outputs actual=0x%0h required=0x%0h", now, snap);
        end
      end else if (last_active) begin
        if (valid_2disp) begin
          o.pc = pc_2disp; o.instr = instr_2disp; o.pred = pred_jump_2disp;
          chk("disp_after_stall", {31'd0, last_stall}, 32'd0);
          if (m_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_disp actual_pc=0x%0h required=no_pulse", o.pc);
          end else begin
            e = m_q.pop_front();
            chk("disp_pc", o.pc, e.pc);
            chk("disp_instr", o.instr, e.instr);
            chk("disp_pred", {31'd0, o.pred}, {31'd0, e.pred});
          end
          disp_log.push_back(o);
          disp_cyc.push_back(cyc);
          $display("disp cyc=%0d pc=0x%0h instr=0x%08h pred=%0d", cyc, o.pc, o.instr, o.pred);
        end
        if (mem_req && !prev_req) begin
          chk("req_addr", mem_addr, m_pc);
          req_log.push_back(mem_addr);
        end
      end
      prev_req = (mem_req === 1'b1);
      snap = now;
      last_frozen = !rst && !rdy;
      last_active = !rst && rdy;
      last_stall  = stall;
      if (rst) begin
        m_pc = 0; m_discard = 0; m_q.delete();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
      end else if (rdy) begin
        if (mem_ack) begin
          if (!rollback_signal && !m_discard) begin
            idx = int'(m_pc[7:2]);
            model_next(m_pc, mem_instr, m_bht[idx], npc, pr);
            e.pc = m_pc; e.instr = mem_instr; e.pred = pr;
            m_q.push_back(e);
            m_pc = npc;
            m_acc++;
          end
          m_discard = 0;
        end else if (rollback_signal && mem_req) begin
          m_discard = 1;
        end
        if (rollback_signal) begin
          m_q.delete();
          m_pc = rollback_pc;
          m_acc = 0;
          rb_req_idx = req_log.size();
          rb_disp_idx = disp_log.size();
        end
        if (upd_valid) begin
          idx = int'(upd_pc[7:2]);
          if (upd_taken && m_bht[idx] < 3) m_bht[idx]++;
          else if (!upd_taken && m_bht[idx] > 0) m_bht[idx]--;
        end
      end
    end
  end

  task automatic wait_req(input int n, input int budget);
    int k = 0;
    while (req_log.size() < n && k < budget) begin tick(); k++; end
    if (req_log.size() < n) begin
      checks++; failures++;
      $display("FAIL timeout_req actual=%0d required=%0d", req_log.size(), n);
    end
  endtask

  task automatic wait_disp(input int n, input int budget);
    int k = 0;
    while (disp_log.size() < n && k < budget) begin tick(); k++; end
    if (disp_log.size() < n) begin
      checks++; failures++;
      $display("FAIL timeout_disp actual=%0d required=%0d", disp_log.size(), n);
    end
  endtask

  task automatic rollback_to(input logic [31:0] target);
    rollback_pc = target;
    rollback_signal = 1'b1;
    tick();
    rollback_signal = 1'b0;
  endtask

  initial begin : stim
    int k, d0;
    rst = 1; rdy = 1; rollback_signal = 0; rollback_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; stall = 0;
    repeat (3) tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, valid_2disp}, 32'd0);
    chk("rst_pc_2disp", pc_2disp, 32'd0);
    chk("rst_instr_2disp", instr_2disp, 32'd0);
    chk("rst_pred", {31'd0, pred_jump_2disp}, 32'd0);
    rst = 0;

    // Sequential fetch, JAL redirect, first BEQ predicted not-taken
    wait_req(11, 200);
    chk("seq_req0", req_log[0], 32'h0);
    chk("seq_req1", req_log[1], 32'h4);
    chk("seq_req2", req_log[2], 32'h8);
    chk("jal_target", req_log[5], 32'h30);
    chk("beq_nt_next", req_log[10], 32'h44);
    wait_disp(10, 200);
    chk("disp0_pc", disp_log[0].pc, 32'h0);
    chk("disp1_pc", disp_log[1].pc, 32'h4);
    chk("disp2_pc", disp_log[2].pc, 32'h8);
    chk("disp0_pred", {31'd0, disp_log[0].pred}, 32'd0);
    chk("disp_jal_pred", {31'd0, disp_log[4].pred}, 32'd1);
    chk("disp_beq_nt_pred", {31'd0, disp_log[9].pred}, 32'd0);

    // Train BEQ at 0x40 taken twice, then refetch it
    upd_pc = 32'h40; upd_taken = 1; upd_valid = 1;
    tick(); tick();
    upd_valid = 0;
    rollback_to(32'h40);
    wait_req(rb_req_idx + 2, 100);
    chk("beq_refetch", req_log[rb_req_idx], 32'h40);
    chk("beq_taken_next", req_log[rb_req_idx + 1], 32'h38);
    wait_disp(rb_disp_idx + 1, 100);
    chk("beq_taken_pc", disp_log[rb_disp_idx].pc, 32'h40);
    chk("beq_taken_pred", {31'd0, disp_log[rb_disp_idx].pred}, 32'd1);

    // Back-pressure: queue fills to IQ_DEPTH and fetching stops
    stall = 1;
    rollback_to(32'h200);
    repeat (14) tick();
    chk("full_fetch_count", m_acc, 4);
    chk("full_no_req", {31'd0, mem_req}, 32'd0);
    chk("full_no_disp", disp_log.size(), rb_disp_idx);
    stall = 0;
    d0 = disp_log.size();
    wait_disp(d0 + 4, 50);
    for (int i = 0; i < 4; i++) chk("drain_pc", disp_log[d0 + i].pc, 32'h200 + 32'(4 * i));
    chk("drain_back_to_back", disp_cyc[d0 + 3] - disp_cyc[d0], 3);
    wait_req(rb_req_idx + 5, 50);
    chk("resume_req", req_log[rb_req_idx + 4], 32'h210);

    // Rollback while a request is outstanding; its late ack is discarded
    ack_delay = 4;
    rollback_to(32'h0);
    k = 0;
    while (!(mem_req && mem_addr == 32'h8) && k < 100) begin tick(); k++; end
    chk("busy_on_8", {31'd0, mem_req && mem_addr == 32'h8}, 32'd1);
    rollback_to(32'h100);
    wait_req(rb_req_idx + 1, 100);
    chk("flush_next_req", req_log[rb_req_idx], 32'h100);
    wait_disp(rb_disp_idx + 1, 100);
    chk("flush_first_disp", disp_log[rb_disp_idx].pc, 32'h100);

    // Freeze mid-request, then rollback coincident with the ack
    ack_delay = 3;
    k = 0;
    while (!mem_req && k < 50) begin tick(); k++; end
    rdy = 0;
    repeat (5) tick();
    chk("freeze_req_held", {31'd0, mem_req}, 32'd1);
    chk("freeze_addr_held", mem_addr, m_pc);
    rdy = 1;
    k = 0;
    do begin
      @(posedge clk);
      #3;
      k++;
    end while (!mem_ack && k < 50);
    chk("ack_seen", {31'd0, mem_ack}, 32'd1);
    rollback_pc = 32'h300;
    rollback_signal = 1;
    tick();
    rollback_signal = 0;
    wait_req(rb_req_idx + 1, 100);
    chk("coincident_next_req", req_log[rb_req_idx], 32'h300);
    wait_disp(rb_disp_idx + 1, 100);
    chk("coincident_first_disp", disp_log[rb_disp_idx].pc, 32'h300);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
